// File: rtl/rv32i_mux_pkg.sv
// Shared types for the registered N:1 operand selector: buffer state encoding,
// the largest supported input count and the default RV32 entry layout.
package rv32i_mux_pkg;

  localparam int MUX_N_MAX = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // RV32 layout of one buffered entry; the top builds the same shape at its own WIDTH/SEL_W.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  sel;
    logic        err;
  } mux_entry_t;

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready buffer (main reg M plus skid reg S) with registered in_ready.
// Entries leave strictly in arrival order; the internal state register is named state.
module mux_skid_buf
  import rv32i_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_entry,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_entry,
  output logic         out_valid,
  input  logic         out_ready
);

  // Handshake: a word moves on any rising edge where its valid and ready are both high;
  // out_entry/out_valid hold steady while out_valid & !out_ready, and in_ready is a flop.
  buf_state_t   state, state_next;
  logic [W-1:0] m_q, m_next;
  logic [W-1:0] s_q, s_next;
  logic         accept, drain;

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_entry = m_q;

  always_comb begin
    state_next = state;
    m_next     = m_q;
    s_next     = s_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          m_next     = in_entry;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (accept && drain) begin
          m_next = in_entry;
        end else if (accept) begin
          s_next     = in_entry;
          state_next = FULL;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move
        if (drain) begin
          m_next     = s_q;
          state_next = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      m_q      <= '0;
      s_q      <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      m_q      <= m_next;
      s_q      <= s_next;
      in_ready <= (state_next != FULL);
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Parametrised N:1 selector with a registered, skid-buffered valid/ready output.
// Define MUX_SEL_ERR_EN to flag out-of-range selects on out_err; otherwise out_err stays 0.
module mux_n_reg
  import rv32i_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  if (N < 2 || N > MUX_N_MAX) begin : g_bad_n
    $error("mux_n_reg: N must be in 2..%0d", MUX_N_MAX);
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  entry_t           in_entry, out_entry;

  // Indices with no matching input fall through to zero data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (in_sel == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef MUX_SEL_ERR_EN
  assign sel_err = (int'(in_sel) >= N);
`else
  assign sel_err = 1'b0;
`endif

  always_comb begin
    in_entry      = '0;
    in_entry.data = sel_data;
    in_entry.sel  = in_sel;
    in_entry.err  = sel_err;
  end

  mux_skid_buf #(
    .W($bits(entry_t))
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (in_entry),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_entry (out_entry),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data = out_entry.data;
  assign out_sel  = out_entry.sel;
  assign out_err  = out_entry.err;

endmodule

// File: tb/tb_mux_n_reg.sv
// Self-checking bench for mux_n_reg: directed handshake scenarios plus a random
// valid/ready run against a scoreboard queue; a second N=5 instance covers bad selects.
module tb_mux_n_reg;
  import rv32i_mux_pkg::*;

  localparam int WIDTH  = 32;
  localparam int N      = 4;
  localparam int SEL_W  = 2;
  localparam int EW     = WIDTH + SEL_W + 1;
  localparam int N5     = 5;
  localparam int SEL5_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT (N=4) ----------------
  logic [WIDTH-1:0]   words [N];
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid, in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_err, out_valid, out_ready;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = words[i];
  end

  mux_n_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // ---------------- second DUT (N=5) ----------------
  logic [WIDTH-1:0]    words5 [N5];
  logic [N5*WIDTH-1:0] in_data5;
  logic [SEL5_W-1:0]   in_sel5;
  logic                in_valid5, in_ready5;
  logic [WIDTH-1:0]    out_data5;
  logic [SEL5_W-1:0]   out_sel5;
  logic                out_err5, out_valid5, out_ready5;

  always_comb begin
    for (int i = 0; i < N5; i++) in_data5[i*WIDTH +: WIDTH] = words5[i];
  end

  mux_n_reg #(.WIDTH(WIDTH), .N(N5)) dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_sel(in_sel5), .in_valid(in_valid5),
    .in_ready(in_ready5), .out_data(out_data5), .out_sel(out_sel5), .out_err(out_err5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

`ifdef MUX_SEL_ERR_EN
  localparam logic EXP_BAD_ERR = 1'b1;
`else
  localparam logic EXP_BAD_ERR = 1'b0;
`endif

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference selection: {err, sel, data} for the main instance.
  function automatic logic [EW-1:0] model(input logic [SEL_W-1:0] sel);
    logic [WIDTH-1:0] d;
    logic             e;
    d = (int'(sel) < N) ? words[sel] : '0;
    e = (int'(sel) >= N) ? EXP_BAD_ERR : 1'b0;
    return {e, sel, d};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  int n_pushed  = 0;
  int n_popped  = 0;
  int n_flushed = 0;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(in_sel));
      n_pushed++;
    end
  end

  logic          prev_hold;
  logic [EW-1:0] prev_word;
  logic [EW-1:0] exp_w;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check_val("hold_stable", 64'({out_valid, out_err, out_sel, out_data}), 64'({1'b1, prev_word}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_out", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_w = exp_q.pop_front();
          check_val("sb_out", 64'({out_err, out_sel, out_data}), 64'(exp_w));
          n_popped++;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_word = {out_err, out_sel, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input int sel, input logic [WIDTH-1:0] val);
    words[sel] = val;
    in_sel     = SEL_W'(sel);
    in_valid   = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_sel     = '0;
    in_valid5  = 1'b0;
    out_ready5 = 1'b0;
    in_sel5    = '0;
    for (int i = 0; i < N; i++) words[i] = '0;
    for (int i = 0; i < N5; i++) words5[i] = WIDTH'(32'h1111_0000 + i);
    repeat (2) step();
    rst = 1'b0;

    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_out_sel", 64'(out_sel), 64'd0);
    check_val("rst_out_err", 64'(out_err), 64'd0);
    check_val("rst_in_ready5", 64'(in_ready5), 64'd1);

    // Single transfer, one-cycle latency
    out_ready = 1'b1;
    push_main(2, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("t1_valid", 64'(out_valid), 64'd1);
    check_val("t1_data", 64'(out_data), 64'hDEAD_BEEF);
    check_val("t1_sel", 64'(out_sel), 64'd2);

    // Back-to-back: one output per cycle, in_ready stays high
    for (int i = 0; i < 8; i++) begin
      push_main(i % N, $urandom);
      @(negedge clk);
      check_val("t1_b2b_in_ready", 64'(in_ready), 64'd1);
      check_val("t1_b2b_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Backpressure fills the skid, then drains A before B
    out_ready = 1'b0;
    push_main(0, 32'hAAAA_0001);
    push_main(1, 32'hBBBB_0002);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("t2_state_full", 64'(dut.u_buf.state), 64'(FULL));
    check_val("t2_in_ready", 64'(in_ready), 64'd0);
    check_val("t2_data_a", 64'(out_data), 64'hAAAA_0001);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check_val("t2_drain_a", 64'(out_data), 64'hAAAA_0001);
    step();
    @(negedge clk);
    check_val("t2_drain_b", 64'(out_data), 64'hBBBB_0002);
    check_val("t2_in_ready_back", 64'(in_ready), 64'd1);
    step();

    // in_data changes without in_valid have no effect
    for (int i = 0; i < 3; i++) begin
      words[1] = $urandom;
      in_sel   = 2'd1;
      step();
    end
    @(negedge clk);
    check_val("t3_idle_valid", 64'(out_valid), 64'd0);
    check_val("t3_idle_data", 64'(out_data), 64'hBBBB_0002);

    // Out-of-range select on the N=5 instance
    out_ready5 = 1'b1;
    in_sel5    = 3'd6;
    in_valid5  = 1'b1;
    step();
    in_sel5 = 3'd4;
    @(negedge clk);
    check_val("t4_bad_valid", 64'(out_valid5), 64'd1);
    check_val("t4_bad_data", 64'(out_data5), 64'd0);
    check_val("t4_bad_err", 64'(out_err5), 64'(EXP_BAD_ERR));
    check_val("t4_bad_sel", 64'(out_sel5), 64'd6);
    step();
    in_valid5 = 1'b0;
    @(negedge clk);
    check_val("t4_sel4_data", 64'(out_data5), 64'h1111_0004);
    check_val("t4_sel4_err", 64'(out_err5), 64'd0);
    step();

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    push_main(0, 32'hC0C0_0000);
    push_main(3, 32'hC0C0_0003);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("t5_state_full", 64'(dut.u_buf.state), 64'(FULL));
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_flushed += exp_q.size();
    exp_q.delete();
    @(negedge clk);
    check_val("t5_valid", 64'(out_valid), 64'd0);
    check_val("t5_in_ready", 64'(in_ready), 64'd1);
    check_val("t5_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_val("t5_no_ghost", 64'(out_valid), 64'd0);

    // Random valid/ready traffic
    for (int c = 0; c < 10000; c++) begin
      words[$urandom_range(0, N-1)] = $urandom;
      in_sel    = SEL_W'($urandom_range(0, N-1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check_val("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    check_val("t6_count", 64'(n_popped), 64'(n_pushed - n_flushed));
    check_val("t6_end_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
